// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types used by the memory model and its requesters.
//   word_t           : 32-bit data word
//   ramstate_t       : response state seen on the ramstate bus
//   ram_ctrl_state_t : internal FSM state of ram_access_ctrl, encoded
//                      identically to ramstate_t so it can drive the bus
//   RAM_LAT_MAX      : largest supported access latency (BUSY cycles)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int unsigned RAM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    RC_FREE   = 2'd0,
    RC_BUSY   = 2'd1,
    RC_ACCESS = 2'd2,
    RC_ERROR  = 2'd3
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_array.sv
// Word storage for ram_access_ctrl.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears every word
//   wen_i   : write enable, write happens at the rising edge
//   widx_i  : write word index
//   wdata_i : write data
//   ridx_i  : read word index
//   rdata_o : combinational read data
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wen_i,
  input  logic [AW-1:0] widx_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] ridx_i,
  output logic [31:0]   rdata_o
);

  word_t mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wen_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/ram_access_ctrl.sv
// Main-memory model with programmable access latency.
// A level request (ramREN xor ramWEN) is latched, held in BUSY for LAT
// cycles, then served for exactly one ACCESS cycle. Changing the op or
// word index during BUSY restarts the latency; simultaneous REN/WEN or
// an address beyond DEPTH words goes to ERROR until the request clears.
//   CLK      : clock, rising edge
//   nRST     : asynchronous active-low reset
//   ramREN   : read request (level)
//   ramWEN   : write request (level)
//   ramaddr  : byte address, word index = ramaddr[AW+1:2]
//   ramstore : write data, committed at the edge ending ACCESS
//   ramload  : read data during a read ACCESS, 0 otherwise
//   ramstate : FREE / BUSY / ACCESS / ERROR
module ram_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int unsigned CW     = $clog2(RAM_LAT_MAX + 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

  ram_ctrl_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_wr_q, op_wr_d;
  logic [AW-1:0]   idx_q, idx_d;

  logic          req;
  logic          illegal;
  logic [AW-1:0] idx;
  logic          unused_addr_bits;
  logic [31:0]   rdata;

  assign idx              = ramaddr[AW+1:2];
  assign unused_addr_bits = ^ramaddr[1:0];
  assign req              = ramREN ^ ramWEN;
  assign illegal          = (ramREN & ramWEN) | (req & (|ramaddr[31:AW+2]));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RC_FREE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    case (state_q)
      RC_FREE: begin
        if (illegal) begin
          state_d = RC_ERROR;
        end else if (req) begin
          state_d = RC_BUSY;
          op_wr_d = ramWEN;
          idx_d   = idx;
          cnt_d   = LAT_M1;
        end
      end
      RC_BUSY: begin
        if (illegal) begin
          state_d = RC_ERROR;
        end else if (!req) begin
          state_d = RC_FREE;
        end else if ((ramWEN != op_wr_q) || (idx != idx_q)) begin
          // requester changed its mind: relatch and restart the latency
          op_wr_d = ramWEN;
          idx_d   = idx;
          cnt_d   = LAT_M1;
        end else if (cnt_q == '0) begin
          state_d = RC_ACCESS;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RC_ACCESS: begin
        if (illegal) begin
          state_d = RC_ERROR;
        end else if (req) begin
          state_d = RC_BUSY;
          op_wr_d = ramWEN;
          idx_d   = idx;
          cnt_d   = LAT_M1;
        end else begin
          state_d = RC_FREE;
        end
      end
      RC_ERROR: begin
        if (!illegal) begin
          state_d = RC_FREE;
        end
      end
      default: state_d = RC_FREE;
    endcase
  end

  // Write commits unconditionally at the edge ending ACCESS; the
  // latched index is used so the requester may already move on.
  ram_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram_array (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .wen_i  ((state_q == RC_ACCESS) && op_wr_q),
    .widx_i (idx_q),
    .wdata_i(ramstore),
    .ridx_i (idx_q),
    .rdata_o(rdata)
  );

  assign ramload  = ((state_q == RC_ACCESS) && !op_wr_q) ? rdata : '0;
  assign ramstate = state_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned LAT     = 2;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned AW      = 10;
  localparam int          ACC_LAT = LAT + 1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int checks   = 0;
  int failures = 0;

  word_t model_mem [DEPTH];

  always #5 CLK = ~CLK;

  ram_access_ctrl #(
    .LAT  (LAT),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  // Steps until ACCESS is seen; gives up after 40 cycles.
  task automatic wait_access(output int n);
    n = 0;
    while (ramstate !== 2'(ACCESS) && n < 40) begin
      tick();
      n++;
    end
  endtask

  // One transaction from FREE; returns cycles to ACCESS, data seen in
  // ACCESS and the state one cycle after the request is dropped.
  task automatic run_txn(input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, output int lat,
                         output logic [31:0] load, output logic [1:0] st);
    ramREN   = !wr;
    ramWEN   = wr;
    ramaddr  = addr;
    ramstore = data;
    wait_access(lat);
    load   = ramload;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    tick();
    st = ramstate;
  endtask

  task automatic test_reset();
    ramREN = 0; ramWEN = 0; ramaddr = '0; ramstore = '0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (ramstate !== 2'(FREE)) begin
      failures++; $display("FAIL reset_state: got %0d expected %0d", ramstate, FREE);
    end
    checks++;
    if (ramload !== 32'h0) begin
      failures++; $display("FAIL reset_load: got %h expected 0", ramload);
    end
    nRST = 1'b1;
    model_clear();
    tick();
    checks++;
    if (ramstate !== 2'(FREE)) begin
      failures++; $display("FAIL reset_idle: got %0d expected %0d", ramstate, FREE);
    end
  endtask

  task automatic test_basic_read();
    logic [1:0] exp_st;
    ramREN  = 1'b1;
    ramaddr = 32'h10;
    for (int c = 1; c <= ACC_LAT; c++) begin
      tick();
      exp_st = (c <= int'(LAT)) ? 2'(BUSY) : 2'(ACCESS);
      checks++;
      if (ramstate !== exp_st) begin
        failures++; $display("FAIL basic_state_c%0d: got %0d expected %0d", c, ramstate, exp_st);
      end
    end
    checks++;
    if (ramload !== model_mem[4]) begin
      failures++; $display("FAIL basic_load: got %h expected %h", ramload, model_mem[4]);
    end
    ramREN = 1'b0;
    tick();
    checks++;
    if (ramstate !== 2'(FREE) || ramload !== 32'h0) begin
      failures++; $display("FAIL basic_free: got st=%0d load=%h expected st=%0d load=0", ramstate, ramload, FREE);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] load;
    logic [1:0]  st;
    run_txn(1'b1, 32'h40, 32'hDEAD_BEEF, lat, load, st);
    model_mem[16] = 32'hDEAD_BEEF;
    checks++;
    if (lat !== ACC_LAT || load !== 32'h0 || st !== 2'(FREE)) begin
      failures++; $display("FAIL wr_txn: got lat=%0d load=%h st=%0d expected lat=%0d load=0 st=0", lat, load, st, ACC_LAT);
    end
    run_txn(1'b0, 32'h40, 32'h0, lat, load, st);
    checks++;
    if (lat !== ACC_LAT || load !== model_mem[16]) begin
      failures++; $display("FAIL rd_after_wr: got lat=%0d load=%h expected lat=%0d load=%h", lat, load, ACC_LAT, model_mem[16]);
    end
    run_txn(1'b0, 32'h43, 32'h0, lat, load, st);
    checks++;
    if (load !== model_mem[16]) begin
      failures++; $display("FAIL rd_lowbits: got %h expected %h", load, model_mem[16]);
    end
  endtask

  task automatic test_abort_restart();
    int lat, n;
    logic [31:0] load, d;
    logic [1:0]  st;
    d = $urandom;
    run_txn(1'b1, 32'h20, d, lat, load, st);
    model_mem[8] = d;
    // address change after one BUSY cycle restarts the latency
    ramREN  = 1'b1;
    ramaddr = 32'h10;
    tick();
    tick();
    checks++;
    if (ramstate !== 2'(BUSY)) begin
      failures++; $display("FAIL abort_busy: got %0d expected %0d", ramstate, BUSY);
    end
    ramaddr = 32'h20;
    wait_access(n);
    checks++;
    if (n !== ACC_LAT) begin
      failures++; $display("FAIL abort_lat: got %0d expected %0d", n, ACC_LAT);
    end
    checks++;
    if (ramload !== model_mem[8]) begin
      failures++; $display("FAIL abort_load: got %h expected %h", ramload, model_mem[8]);
    end
    ramREN = 1'b0;
    tick();
    // byte-offset change is not a new request
    ramREN  = 1'b1;
    ramaddr = 32'h10;
    tick();
    ramaddr = 32'h13;
    wait_access(n);
    checks++;
    if (n !== int'(LAT) || ramload !== model_mem[4]) begin
      failures++; $display("FAIL lowbit_norestart: got n=%0d load=%h expected n=%0d load=%h", n, ramload, LAT, model_mem[4]);
    end
    ramREN = 1'b0;
    tick();
    // op change restarts and the abandoned write is never committed
    ramWEN   = 1'b1;
    ramaddr  = 32'h30;
    ramstore = ~model_mem[12];
    tick();
    ramWEN = 1'b0;
    ramREN = 1'b1;
    wait_access(n);
    checks++;
    if (n !== ACC_LAT || ramload !== model_mem[12]) begin
      failures++; $display("FAIL op_restart: got n=%0d load=%h expected n=%0d load=%h", n, ramload, ACC_LAT, model_mem[12]);
    end
    ramREN = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n, t, lat;
    logic [31:0] load;
    logic [1:0]  st;
    t = 0;
    ramWEN   = 1'b1;
    ramaddr  = 32'h0;
    ramstore = 32'd1;
    for (int k = 0; k < 3; k++) begin
      wait_access(n);
      t += n;
      checks++;
      if (t !== (k + 1) * ACC_LAT) begin
        failures++; $display("FAIL b2b_cycle_%0d: got %0d expected %0d", k, t, (k + 1) * ACC_LAT);
      end
      model_mem[k] = 32'(k + 1);
      if (k < 2) begin
        ramaddr = 32'(4 * (k + 1));
        tick();
        t++;
        ramstore = 32'(k + 2);
      end else begin
        ramWEN = 1'b0;
        tick();
      end
    end
    checks++;
    if (ramstate !== 2'(FREE)) begin
      failures++; $display("FAIL b2b_free: got %0d expected %0d", ramstate, FREE);
    end
    for (int k = 0; k < 3; k++) begin
      run_txn(1'b0, 32'(4 * k), 32'h0, lat, load, st);
      checks++;
      if (load !== model_mem[k]) begin
        failures++; $display("FAIL b2b_readback_%0d: got %h expected %h", k, load, model_mem[k]);
      end
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [31:0] load, d;
    logic [1:0]  st;
    // both strobes
    ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h0; ramstore = ~model_mem[0];
    tick();
    checks++;
    if (ramstate !== 2'(ERROR)) begin
      failures++; $display("FAIL both_error: got %0d expected %0d", ramstate, ERROR);
    end
    tick();
    checks++;
    if (ramstate !== 2'(ERROR) || ramload !== 32'h0) begin
      failures++; $display("FAIL both_hold: got st=%0d load=%h expected st=%0d load=0", ramstate, ramload, ERROR);
    end
    // legal request while in ERROR only returns to FREE first
    ramWEN = 1'b0;
    tick();
    checks++;
    if (ramstate !== 2'(FREE)) begin
      failures++; $display("FAIL err_to_free: got %0d expected %0d", ramstate, FREE);
    end
    tick();
    checks++;
    if (ramstate !== 2'(BUSY)) begin
      failures++; $display("FAIL free_to_busy: got %0d expected %0d", ramstate, BUSY);
    end
    ramREN = 1'b0;
    tick();
    run_txn(1'b0, 32'h0, 32'h0, lat, load, st);
    checks++;
    if (load !== model_mem[0]) begin
      failures++; $display("FAIL both_nowrite: got %h expected %h", load, model_mem[0]);
    end
    // out-of-range address during BUSY aborts the write
    ramWEN = 1'b1; ramaddr = 32'h8; ramstore = ~model_mem[2];
    tick();
    ramaddr = 32'h1008;
    tick();
    checks++;
    if (ramstate !== 2'(ERROR)) begin
      failures++; $display("FAIL busy_abort_error: got %0d expected %0d", ramstate, ERROR);
    end
    ramWEN = 1'b0;
    tick();
    checks++;
    if (ramstate !== 2'(FREE)) begin
      failures++; $display("FAIL busy_abort_free: got %0d expected %0d", ramstate, FREE);
    end
    run_txn(1'b0, 32'h8, 32'h0, lat, load, st);
    checks++;
    if (load !== model_mem[2]) begin
      failures++; $display("FAIL abort_nowrite: got %h expected %h", load, model_mem[2]);
    end
    // first out-of-range word
    ramREN = 1'b1; ramaddr = 32'h0000_1000;
    tick();
    checks++;
    if (ramstate !== 2'(ERROR)) begin
      failures++; $display("FAIL oor_error: got %0d expected %0d", ramstate, ERROR);
    end
    ramREN = 1'b0;
    tick();
    // high address bits without a request are harmless
    ramaddr = 32'hFFFF_0000;
    tick();
    checks++;
    if (ramstate !== 2'(FREE)) begin
      failures++; $display("FAIL idle_highaddr: got %0d expected %0d", ramstate, FREE);
    end
    // last legal word
    d = $urandom;
    run_txn(1'b1, 32'h0000_0FFC, d, lat, load, st);
    model_mem[DEPTH-1] = d;
    run_txn(1'b0, 32'h0000_0FFF, 32'h0, lat, load, st);
    checks++;
    if (lat !== ACC_LAT || load !== model_mem[DEPTH-1]) begin
      failures++; $display("FAIL last_word: got lat=%0d load=%h expected lat=%0d load=%h", lat, load, ACC_LAT, model_mem[DEPTH-1]);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [31:0] load;
    logic [1:0]  st;
    ramWEN = 1'b1; ramaddr = 32'h80; ramstore = 32'h1234;
    tick();
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (ramstate !== 2'(FREE)) begin
      failures++; $display("FAIL async_reset: got %0d expected %0d", ramstate, FREE);
    end
    ramWEN = 1'b0;
    model_clear();
    tick();
    nRST = 1'b1;
    tick();
    run_txn(1'b0, 32'h80, 32'h0, lat, load, st);
    checks++;
    if (load !== model_mem[32]) begin
      failures++; $display("FAIL reset_lost_write: got %h expected %h", load, model_mem[32]);
    end
    run_txn(1'b0, 32'h40, 32'h0, lat, load, st);
    checks++;
    if (load !== model_mem[16]) begin
      failures++; $display("FAIL reset_cleared: got %h expected %h", load, model_mem[16]);
    end
  endtask

  task automatic test_random();
    int lat, idx;
    bit wr;
    logic [31:0] addr, data, load;
    logic [1:0]  st;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          ramREN = 1'b1; ramWEN = 1'b1; ramaddr = $urandom;
        end else begin
          ramREN = 1'b1; ramWEN = 1'b0;
          ramaddr = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)};
        end
        tick();
        checks++;
        if (ramstate !== 2'(ERROR)) begin
          failures++; $display("FAIL rnd_illegal_%0d: got %0d expected %0d addr=%h", it, ramstate, ERROR, ramaddr);
        end
        ramREN = 1'b0; ramWEN = 1'b0;
        tick();
      end else begin
        wr   = 1'($urandom_range(0, 1));
        idx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                           : int'($urandom_range(0, 15));
        addr = 32'(idx * 4 + int'($urandom_range(0, 3)));
        data = $urandom;
        run_txn(wr, addr, data, lat, load, st);
        checks++;
        if (lat !== ACC_LAT || st !== 2'(FREE)) begin
          failures++; $display("FAIL rnd_timing_%0d: got lat=%0d st=%0d expected lat=%0d st=0", it, lat, st, ACC_LAT);
        end
        checks++;
        if (wr) begin
          if (load !== 32'h0) begin
            failures++; $display("FAIL rnd_wrload_%0d: got %h expected 0", it, load);
          end
          model_mem[widx(addr)] = data;
        end else if (load !== model_mem[idx]) begin
          failures++; $display("FAIL rnd_read_%0d: got %h expected %h idx=%0d", it, load, model_mem[idx], idx);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_read();
    test_write_read();
    test_abort_restart();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
